// File: rtl/otter_io_timer_pkg.sv
// -----------------------------------------------------------------------------
// otter_io_timer_pkg
// Purpose : Shared definitions for the OTTER IO/timer responder. These are the
//           register word offsets, the CTRL/STATUS layouts and the reset
//           constants. The RTL and the bench both import this package, so the
//           register map is defined in one place only.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package otter_io_timer_pkg;

    // Word offsets within the 32-byte window (iobus_addr[4:2])
    localparam logic [2:0] OFF_GPIO_IN  = 3'd0;
    localparam logic [2:0] OFF_GPIO_OUT = 3'd1;
    localparam logic [2:0] OFF_CTRL     = 3'd2;
    localparam logic [2:0] OFF_PRESCALE = 3'd3;
    localparam logic [2:0] OFF_COMPARE  = 3'd4;
    localparam logic [2:0] OFF_COUNT    = 3'd5;
    localparam logic [2:0] OFF_STATUS   = 3'd6;
    localparam logic [2:0] OFF_RSVD     = 3'd7;

    // STATUS bit indices, used when decoding write-1-to-clear data
    localparam int STAT_MATCH = 0;
    localparam int STAT_CHG   = 1;

    // CTRL layout: bit 0 EN, 1 AUTORELOAD, 2 MATCH_IE, 3 CHG_IE
    typedef struct packed {
        logic chg_ie;
        logic match_ie;
        logic autoreload;
        logic en;
    } ctrl_t;

    // STATUS layout: bit 0 MATCH, bit 1 GPIO_CHG
    typedef struct packed {
        logic chg;
        logic match;
    } status_t;

    localparam ctrl_t       CTRL_RST    = '0;
    localparam status_t     STATUS_RST  = '0;
    localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;
    localparam logic [31:0] COUNT_RST   = 32'h0000_0000;

endpackage

// File: rtl/otter_io_timer_if.sv
// -----------------------------------------------------------------------------
// otter_io_timer_if
// Purpose : The hart's iobus, bundled as one interface.
// Signals : iobus_addr  byte address from the hart
//           iobus_out   write data (bytes the store does not cover are already zero)
//           iobus_wr    write qualifier, high for one cycle per store
//           iobus_in    read data returned to the hart (combinational)
// Modports: master (hart side), slave (IO responder side)
// -----------------------------------------------------------------------------
interface otter_io_timer_if;
    logic [31:0] iobus_addr;
    logic [31:0] iobus_out;
    logic        iobus_wr;
    logic [31:0] iobus_in;

    modport master (
        output iobus_addr,
        output iobus_out,
        output iobus_wr,
        input  iobus_in
    );

    modport slave (
        input  iobus_addr,
        input  iobus_out,
        input  iobus_wr,
        output iobus_in
    );
endinterface

// File: rtl/otter_io_sync.sv
// -----------------------------------------------------------------------------
// otter_io_sync
// Purpose : N-bit two-flop synchronizer for asynchronous inputs. Each bit is
//           synchronized on its own, so a multi-bit bus is not guaranteed to
//           be coherent in any single cycle.
// Ports   : clk    system clock
//           rst_n  asynchronous active-low reset (both stages cleared)
//           d_i    asynchronous input
//           q_o    synchronized output (2-cycle latency)
// -----------------------------------------------------------------------------
module otter_io_sync #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    logic [N-1:0] meta_q;
    logic [N-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/otter_io_timer.sv
// -----------------------------------------------------------------------------
// otter_io_timer
// Purpose : Memory-mapped IO responder on the OTTER iobus. It contains:
//           - GPIO input, synchronized, with change detection
//           - a GPIO output register
//           - a prescaled 32-bit timer with a compare register, in one-shot
//             or autoreload mode
//           - a registered level interrupt
//           Read data is combinational from the address and the registers.
//           Writes are full-word.
// Ports   : clk     system clock
//           rst_n   asynchronous active-low reset
//           bus     iobus (slave modport): addr / out / wr / in
//           gpio_i  asynchronous GPIO inputs (GPIO_W)
//           gpio_o  GPIO output register (GPIO_W)
//           irq     level interrupt, registered
// Map     : 0x00 GPIO_IN RO, 0x04 GPIO_OUT, 0x08 CTRL, 0x0C PRESCALE,
//           0x10 COMPARE, 0x14 COUNT, 0x18 STATUS (W1C), 0x1C reserved
// -----------------------------------------------------------------------------
module otter_io_timer
    import otter_io_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
    parameter int          GPIO_W    = 16,
    parameter int          PRE_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    otter_io_timer_if.slave     bus,
    input  logic [GPIO_W-1:0]   gpio_i,
    output logic [GPIO_W-1:0]   gpio_o,
    output logic                irq
);

    // ---------------------------------------------------------------- state
    logic [GPIO_W-1:0] gpio_q,     gpio_d;
    logic [GPIO_W-1:0] hist_q;
    ctrl_t             ctrl_q,     ctrl_d;
    logic [PRE_W-1:0]  prescale_q, prescale_d;
    logic [PRE_W-1:0]  pcnt_q,     pcnt_d;
    logic [31:0]       compare_q,  compare_d;
    logic [31:0]       count_q,    count_d;
    status_t           status_q,   status_d;
    logic              irq_q,      irq_d;

    logic [GPIO_W-1:0] gpio_sync;
    logic [31:0]       rdata;

    // ---------------------------------------------------------------- decode
    logic       hit;
    logic [2:0] off;
    logic       wr_en;
    logic       unused_addr_lsbs;

    assign hit   = (bus.iobus_addr[31:5] == BASE_ADDR[31:5]);
    assign off   = bus.iobus_addr[4:2];
    assign wr_en = hit & bus.iobus_wr;
    // Byte offset bits carry no meaning because every access is a full word.
    assign unused_addr_lsbs = ^bus.iobus_addr[1:0];

    // ---------------------------------------------------------------- input sync
    otter_io_sync #(
        .N (GPIO_W)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (gpio_i),
        .q_o   (gpio_sync)
    );

    // ---------------------------------------------------------------- next state
    logic tick;
    logic match_set;
    logic chg_set;

    always_comb begin
        gpio_d     = gpio_q;
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        compare_d  = compare_q;
        count_d    = count_q;
        status_d   = status_q;
        match_set  = 1'b0;

        tick    = ctrl_q.en && (pcnt_q == prescale_q);
        chg_set = (gpio_sync != hist_q);

        // Prescaler: it is held at zero while the timer is disabled, and a
        // CTRL write restarts the prescale period.
        if (!ctrl_q.en || tick || (wr_en && off == OFF_CTRL)) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PRE_W'(1);
        end

        // Timer step on a tick. On a match, one-shot mode holds COUNT and
        // clears EN, while autoreload mode restarts from zero. A wrap from
        // all-ones back to zero does not raise any flag.
        if (tick) begin
            if (count_q == compare_q) begin
                match_set = 1'b1;
                if (ctrl_q.autoreload) begin
                    count_d = '0;
                end else begin
                    ctrl_d.en = 1'b0;
                end
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        // Bus writes are applied after the timer step, so a write in the
        // same cycle overrides the timer's update of COUNT or EN.
        if (wr_en) begin
            case (off)
                OFF_GPIO_OUT: gpio_d     = bus.iobus_out[GPIO_W-1:0];
                OFF_CTRL:     ctrl_d     = ctrl_t'(bus.iobus_out[3:0]);
                OFF_PRESCALE: prescale_d = bus.iobus_out[PRE_W-1:0];
                OFF_COMPARE:  compare_d  = bus.iobus_out;
                OFF_COUNT:    count_d    = bus.iobus_out;
                OFF_STATUS: begin
                    if (bus.iobus_out[STAT_MATCH]) status_d.match = 1'b0;
                    if (bus.iobus_out[STAT_CHG])   status_d.chg   = 1'b0;
                end
                default: ;
            endcase
        end

        // A flag that sets in the same cycle as a write-1-to-clear stays set.
        if (match_set) status_d.match = 1'b1;
        if (chg_set)   status_d.chg   = 1'b1;

        irq_d = (status_q.match & ctrl_q.match_ie) | (status_q.chg & ctrl_q.chg_ie);
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_q     <= '0;
            hist_q     <= '0;
            ctrl_q     <= CTRL_RST;
            prescale_q <= '0;
            pcnt_q     <= '0;
            compare_q  <= COMPARE_RST;
            count_q    <= COUNT_RST;
            status_q   <= STATUS_RST;
            irq_q      <= 1'b0;
        end else begin
            gpio_q     <= gpio_d;
            hist_q     <= gpio_sync;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            compare_q  <= compare_d;
            count_q    <= count_d;
            status_q   <= status_d;
            irq_q      <= irq_d;
        end
    end

    // ---------------------------------------------------------------- read mux
    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                OFF_GPIO_IN:  rdata[GPIO_W-1:0] = gpio_sync;
                OFF_GPIO_OUT: rdata[GPIO_W-1:0] = gpio_q;
                OFF_CTRL:     rdata[3:0]        = ctrl_q;
                OFF_PRESCALE: rdata[PRE_W-1:0]  = prescale_q;
                OFF_COMPARE:  rdata             = compare_q;
                OFF_COUNT:    rdata             = count_q;
                OFF_STATUS:   rdata[1:0]        = status_q;
                OFF_RSVD:     rdata             = '0;
                default:      rdata             = '0;
            endcase
        end
    end

    assign bus.iobus_in = rdata;
    assign gpio_o       = gpio_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_otter_io_timer.sv
// -----------------------------------------------------------------------------
// tb_otter_io_timer
// Purpose : Self-checking bench for otter_io_timer. A table of register
//           read/write/decode vectors comes first, followed by hand-written
//           sequences for GPIO sync and change, one-shot, autoreload, the W1C
//           race, wrap and COUNT-write races, and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_otter_io_timer;
    import otter_io_timer_pkg::*;

    localparam logic [31:0] B = 32'h1100_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] gpio_i;
    logic [15:0] gpio_o;
    logic        irq;

    int tests  = 0;
    int failed = 0;

    otter_io_timer_if bus ();

    otter_io_timer #(
        .BASE_ADDR (B),
        .GPIO_W    (16),
        .PRE_W     (16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .gpio_i (gpio_i),
        .gpio_o (gpio_o),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        do_wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at posedge+1. The write is captured on the next rising edge, and
    // control returns at that edge+1.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.iobus_addr = a;
        bus.iobus_out  = d;
        bus.iobus_wr   = 1'b1;
        @(posedge clk);
        #1;
        bus.iobus_wr   = 1'b0;
        bus.iobus_out  = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.iobus_addr = a;
        #1;
        d = bus.iobus_in;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] r;
    vec_t        vecs[15];

    initial begin
        vecs[0]  = '{1'b1, B + 32'h04, 32'h0000_A5A5, B + 32'h04, 32'h0000_A5A5};
        vecs[1]  = '{1'b1, B + 32'h08, 32'hFFFF_FFF0, B + 32'h08, 32'h0000_0000};
        vecs[2]  = '{1'b1, B + 32'h0C, 32'hFFFF_1234, B + 32'h0C, 32'h0000_1234};
        vecs[3]  = '{1'b1, B + 32'h10, 32'hDEAD_BEEF, B + 32'h10, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b1, B + 32'h14, 32'h1234_5678, B + 32'h14, 32'h1234_5678};
        vecs[5]  = '{1'b1, B + 32'h1C, 32'hFFFF_FFFF, B + 32'h1C, 32'h0000_0000};
        vecs[6]  = '{1'b1, B + 32'h20, 32'h0000_1234, B + 32'h20, 32'h0000_0000};
        vecs[7]  = '{1'b1, B + 32'h24, 32'h0000_0000, B + 32'h04, 32'h0000_A5A5};
        vecs[8]  = '{1'b0, 32'h0,      32'h0,         B + 32'h13, 32'hDEAD_BEEF};
        vecs[9]  = '{1'b1, B + 32'h17, 32'h0000_CAFE, B + 32'h14, 32'h0000_CAFE};
        vecs[10] = '{1'b0, 32'h0,      32'h0,         32'h0000_0004, 32'h0000_0000};
        vecs[11] = '{1'b1, 32'h2100_0010, 32'h0,      B + 32'h10, 32'hDEAD_BEEF};
        vecs[12] = '{1'b1, B + 32'h18, 32'hFFFF_FFFF, B + 32'h18, 32'h0000_0000};
        vecs[13] = '{1'b0, 32'h0,      32'h0,         B + 32'h00, 32'h0000_0000};
        vecs[14] = '{1'b1, B + 32'h00, 32'h0000_FFFF, B + 32'h00, 32'h0000_0000};

        rst_n          = 1'b0;
        gpio_i         = '0;
        bus.iobus_addr = '0;
        bus.iobus_out  = '0;
        bus.iobus_wr   = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);

        // Values read back right after reset
        rd(B + 32'h10, r); chk("rst_compare", r, 32'hFFFF_FFFF);
        rd(B + 32'h08, r); chk("rst_ctrl",    r, 32'h0);
        rd(B + 32'h14, r); chk("rst_count",   r, 32'h0);
        rd(B + 32'h18, r); chk("rst_status",  r, 32'h0);
        chk("rst_gpio_o", 32'(gpio_o), 32'h0);
        chk("rst_irq",    32'(irq),    32'h0);

        // Register, decode and read-mux vector table
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].do_wr) wr(vecs[i].waddr, vecs[i].wdata);
            rd(vecs[i].raddr, r);
            chk($sformatf("vec%0d", i), r, vecs[i].exp);
        end
        chk("gpio_o_pin", 32'(gpio_o), 32'h0000_A5A5);

        // GPIO synchronizer latency and change flag, with CHG_IE clear
        gpio_i = 16'h0003;
        step(1); rd(B, r); chk("gpio_in_1clk", r, 32'h0);
        step(1); rd(B, r); chk("gpio_in_2clk", r, 32'h3);
        rd(B + 32'h18, r); chk("chg_before", r, 32'h0);
        step(1); rd(B + 32'h18, r); chk("chg_set", r, 32'h2);
        step(2); chk("chg_irq_masked", 32'(irq), 32'h0);
        wr(B + 32'h18, 32'h2);
        rd(B + 32'h18, r); chk("chg_w1c", r, 32'h0);

        // GPIO change with CHG_IE set
        wr(B + 32'h08, 32'h8);
        gpio_i = 16'h0001;
        step(3); chk("chg_irq_early", 32'(irq), 32'h0);
        step(1); chk("chg_irq", 32'(irq), 32'h1);
        wr(B + 32'h18, 32'h2);
        wr(B + 32'h08, 32'h0);
        step(1); chk("chg_irq_clr", 32'(irq), 32'h0);

        // One-shot: PRESCALE=3, COMPARE=5, CTRL=EN|MATCH_IE
        wr(B + 32'h0C, 32'd3);
        wr(B + 32'h10, 32'd5);
        wr(B + 32'h14, 32'd0);
        wr(B + 32'h18, 32'h3);
        wr(B + 32'h08, 32'h5);
        step(19); rd(B + 32'h14, r); chk("os_count19", r, 32'd4);
        step(1);  rd(B + 32'h14, r); chk("os_count20", r, 32'd5);
        step(3);  rd(B + 32'h18, r); chk("os_nomatch23", r, 32'h0);
        step(1);  rd(B + 32'h18, r); chk("os_match24", r, 32'h1);
        chk("os_irq24", 32'(irq), 32'h0);
        rd(B + 32'h08, r); chk("os_en_clr", r, 32'h4);
        step(1);  chk("os_irq25", 32'(irq), 32'h1);
        step(8);  rd(B + 32'h14, r); chk("os_count_hold", r, 32'd5);
        wr(B + 32'h18, 32'h1);
        step(1);  chk("os_irq_clr", 32'(irq), 32'h0);

        // Autoreload: PRESCALE=0, COMPARE=2, CTRL=EN|AUTO|MATCH_IE
        wr(B + 32'h08, 32'h0);
        wr(B + 32'h14, 32'd0);
        wr(B + 32'h0C, 32'd0);
        wr(B + 32'h10, 32'd2);
        wr(B + 32'h18, 32'h3);
        wr(B + 32'h08, 32'h7);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            rd(B + 32'h14, r);
            chk($sformatf("ar_count%0d", k), r, 32'(k % 3));
            rd(B + 32'h18, r);
            chk($sformatf("ar_match%0d", k), r, (k >= 3) ? 32'h1 : 32'h0);
        end

        // W1C race. The match sets again at edges 9 and 12.
        wr(B + 32'h18, 32'h1);                       // edge 7
        rd(B + 32'h18, r); chk("w1c_clear7", r, 32'h0);
        step(1);                                     // edge 8
        wr(B + 32'h18, 32'h1);                       // edge 9, same cycle as set
        rd(B + 32'h18, r); chk("w1c_race", r, 32'h1);
        wr(B + 32'h18, 32'h1);                       // edge 10
        rd(B + 32'h18, r); chk("w1c_clear10", r, 32'h0);
        chk("w1c_irq10", 32'(irq), 32'h1);
        step(1);                                     // edge 11
        chk("w1c_irq11", 32'(irq), 32'h0);

        // Wrap without a flag, then a COUNT write racing a tick
        wr(B + 32'h08, 32'h0);
        wr(B + 32'h18, 32'h3);
        wr(B + 32'h14, 32'hFFFF_FFFF);
        wr(B + 32'h10, 32'd5);
        wr(B + 32'h08, 32'h1);
        step(1);
        rd(B + 32'h14, r); chk("wrap_count", r, 32'h0);
        rd(B + 32'h18, r); chk("wrap_noflag", r, 32'h0);
        wr(B + 32'h14, 32'h100);
        rd(B + 32'h14, r); chk("cnt_wr_wins", r, 32'h100);
        step(1);
        rd(B + 32'h14, r); chk("cnt_after_wr", r, 32'h101);

        // Asynchronous reset while the timer is running with irq asserted
        wr(B + 32'h08, 32'h0);
        wr(B + 32'h14, 32'd0);
        wr(B + 32'h10, 32'd1);
        wr(B + 32'h08, 32'h7);
        step(4);
        chk("pre_rst_irq", 32'(irq), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_irq",    32'(irq),    32'h0);
        chk("arst_gpio_o", 32'(gpio_o), 32'h0);
        rd(B + 32'h14, r); chk("arst_count",   r, 32'h0);
        rd(B + 32'h10, r); chk("arst_compare", r, 32'hFFFF_FFFF);
        rd(B + 32'h08, r); chk("arst_ctrl",    r, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(3);
        rd(B + 32'h14, r); chk("post_rst_count", r, 32'h0);
        rd(B + 32'h00, r); chk("post_rst_gpio_in", r, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
